// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf_if
//  Brief    : Handshake/payload bundle for the pipe_stage_buf skid stage.
//             master = upstream/downstream environment, slave = the stage.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf
//  Brief    : 2-entry skid-buffer pipeline stage. The main register drives the
//             outputs; the skid register catches the payload accepted while
//             downstream stalls. in_ready depends on registered state only.
//             Optional macro PIPE_STAGE_STATS_EN adds a saturating
//             downstream-stall counter on stall_cnt (constant 0 otherwise).
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  wire               CLK,
  input  wire               reset,
  input  wire               flush,
  pipe_stage_buf_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state,    w_stateNext;
  logic [DATA_W-1:0] r_mainData, w_mainDataNext;
  logic [CTRL_W-1:0] r_mainCtrl, w_mainCtrlNext;
  logic [DATA_W-1:0] r_skidData, w_skidDataNext;
  logic [CTRL_W-1:0] r_skidCtrl, w_skidCtrlNext;

  logic w_inFire;
  logic w_outFire;

  assign bus.in_ready  = (r_state != TWO);
  assign bus.out_valid = (r_state != EMPTY);
  assign bus.out_data  = r_mainData;
  assign bus.out_ctrl  = r_mainCtrl;
  assign bus.occupancy = r_state;

  assign w_inFire  = bus.in_valid  & bus.in_ready;
  assign w_outFire = bus.out_valid & bus.out_ready;

  // State and payload registers; reset empties the stage immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_mainData <= '0;
      r_mainCtrl <= '0;
      r_skidData <= '0;
      r_skidCtrl <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_mainData <= w_mainDataNext;
      r_mainCtrl <= w_mainCtrlNext;
      r_skidData <= w_skidDataNext;
      r_skidCtrl <= w_skidCtrlNext;
    end
  end

  // Next-state and payload movement; every path into EMPTY zeroes both slots.
  always_comb begin
    w_stateNext    = r_state;
    w_mainDataNext = r_mainData;
    w_mainCtrlNext = r_mainCtrl;
    w_skidDataNext = r_skidData;
    w_skidCtrlNext = r_skidCtrl;

    if (flush) begin
      w_stateNext    = EMPTY;
      w_mainDataNext = '0;
      w_mainCtrlNext = '0;
      w_skidDataNext = '0;
      w_skidCtrlNext = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            w_stateNext    = ONE;
            w_mainDataNext = bus.in_data;
            w_mainCtrlNext = bus.in_ctrl;
          end
        end
        ONE: begin
          if (w_inFire && w_outFire) begin
            w_mainDataNext = bus.in_data;
            w_mainCtrlNext = bus.in_ctrl;
          end else if (w_inFire) begin
            w_stateNext    = TWO;
            w_skidDataNext = bus.in_data;
            w_skidCtrlNext = bus.in_ctrl;
          end else if (w_outFire) begin
            w_stateNext    = EMPTY;
            w_mainDataNext = '0;
            w_mainCtrlNext = '0;
            w_skidDataNext = '0;
            w_skidCtrlNext = '0;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (w_outFire) begin
            w_stateNext    = ONE;
            w_mainDataNext = r_skidData;
            w_mainCtrlNext = r_skidCtrl;
            w_skidDataNext = '0;
            w_skidCtrlNext = '0;
          end
        end
        default: begin
          w_stateNext    = EMPTY;
          w_mainDataNext = '0;
          w_mainCtrlNext = '0;
          w_skidDataNext = '0;
          w_skidCtrlNext = '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] r_stallCnt;

  // Saturating count of cycles where a valid payload is held back; flush
  // does not touch it, only reset does.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stallCnt;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_buf
//  Brief    : Self-checking bench for pipe_stage_buf. A queue holds the
//             expected contents of the stage (oldest first, at most two);
//             directed scenarios are followed by randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;

  logic CLK;
  logic reset;
  logic flush;

  pipe_stage_buf_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checkCnt = 0;
  int errCnt   = 0;

  // Expected stage contents as {ctrl, data}, oldest entry first.
  logic [CTRL_W+DATA_W-1:0] modelQ[$];
  logic [15:0]              expStall = 16'h0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output with the queue model.
  task automatic checkAll();
    logic [CTRL_W+DATA_W-1:0] head;
    head = (modelQ.size() != 0) ? modelQ[0] : '0;
    check("occupancy", 64'(bus.occupancy), 64'(modelQ.size()));
    check("in_ready",  64'(bus.in_ready),  64'(modelQ.size() < 2));
    check("out_valid", 64'(bus.out_valid), 64'(modelQ.size() != 0));
    check("out_data",  64'(bus.out_data),  64'(head[DATA_W-1:0]));
    check("out_ctrl",  64'(bus.out_ctrl),  64'(head[CTRL_W+DATA_W-1:DATA_W]));
    check("stall_cnt", 64'(bus.stall_cnt), 64'(expStall));
  endtask

  // One clock: drive at negedge, check just after, then advance the model
  // on the posedge using the same inputs the DUT sees.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] id,
                       input logic [CTRL_W-1:0] ic, input logic ordy,
                       input logic fl);
    bit inF, outF;
    @(negedge CLK);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.in_ctrl   = ic;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    checkAll();
    @(posedge CLK);
`ifdef PIPE_STAGE_STATS_EN
    if (modelQ.size() != 0 && !ordy && expStall != 16'hFFFF) expStall = expStall + 16'd1;
`endif
    if (fl) begin
      modelQ.delete();
    end else begin
      inF  = iv && (modelQ.size() < 2);
      outF = (modelQ.size() != 0) && ordy;
      if (outF) void'(modelQ.pop_front());
      if (inF)  modelQ.push_back({ic, id});
    end
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;

    // Reset state, visible before any clock edge.
    #1;
    checkAll();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;

    // Single transfer, first edge after reset, one-cycle latency.
    cycle(1'b1, 32'hDEADBEEF, 16'h1234, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    // Fill both slots under stall, refused third push, then drain in order.
    cycle(1'b1, 32'h11, 16'hA1, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 16'hA2, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 16'hA3, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    // Flush while full with an input offered: everything is dropped.
    cycle(1'b1, 32'h44, 16'hB1, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 16'hB2, 1'b0, 1'b0);
    cycle(1'b1, 32'h66, 16'hB3, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    // Flush in ONE with simultaneous in_fire and out_fire.
    cycle(1'b1, 32'h77, 16'hC1, 1'b1, 1'b0);
    cycle(1'b1, 32'h88, 16'hC2, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    // Back-to-back streaming keeps exactly one entry in flight.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, DATA_W'(i), CTRL_W'(i * 3), 1'b1, 1'b0);
      if (i > 0) check("stream_occ", 64'(bus.occupancy), 64'd1);
    end
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges while full.
    cycle(1'b1, 32'hAA, 16'hD1, 1'b0, 1'b0);
    cycle(1'b1, 32'hBB, 16'hD2, 1'b0, 1'b0);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    #2;
    check("pre_rst_occ", 64'(bus.occupancy), 64'd2);
    reset = 1'b1;
    #1;
    modelQ.delete();
    expStall = 16'h0000;
    checkAll();
    @(negedge CLK);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), DATA_W'($urandom), CTRL_W'($urandom),
            1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 4));
    end

`ifdef PIPE_STAGE_STATS_EN
    // Long stall saturates the counter; flush leaves it saturated.
    cycle(1'b1, 32'hCAFE, 16'hE1, 1'b1, 1'b1);
    cycle(1'b1, 32'hCAFE, 16'hE1, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    end
    check("stall_sat", 64'(bus.stall_cnt), 64'hFFFF);
    cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    check("stall_flush", 64'(bus.stall_cnt), 64'hFFFF);
`else
    // Stall with no statistics: counter stays zero.
    cycle(1'b1, 32'hCAFE, 16'hE1, 1'b1, 1'b1);
    cycle(1'b1, 32'hCAFE, 16'hE1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    end
    check("stall_off", 64'(bus.stall_cnt), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule
`default_nettype wire
